// File: rtl/playback_sequencer.sv
// Sample playback controller: paces ROM fetches at the sample rate and hands samples to PWM.
// Optional pause support (cmd_pause port, PAUSE state) is enabled by defining PLAYBACK_PAUSE_EN.
module playback_sequencer #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned TRACK_LEN = 4096,
    parameter int unsigned CLK_DIV   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_play,
    input  logic              cmd_stop,
`ifdef PLAYBACK_PAUSE_EN
    input  logic              cmd_pause,
`endif
    input  logic              loop_en,
    input  logic [1:0]        track_sel,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [15:0]       rom_data,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = (TRACK_LEN > 1) ? $clog2(TRACK_LEN) : 1;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRACK_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

`ifdef PLAYBACK_PAUSE_EN
    typedef enum logic [2:0] {StIdle, StWait, StReq, StEnd, StPause} state_t;
`else
    typedef enum logic [1:0] {StIdle, StWait, StReq, StEnd} state_t;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] index_q;
    logic [1:0]       track_q;
    logic             tick;
    logic             last_idx;
    logic             count_en;
`ifdef PLAYBACK_PAUSE_EN
    logic             pause_pend_q;
`endif

    // Track base sits in the top two address bits; the index fills the low bits.
    function automatic logic [ADDR_W-1:0] track_addr(input logic [1:0] trk,
                                                     input logic [IDX_W-1:0] idx);
        return {trk, {(ADDR_W-2){1'b0}}} + ADDR_W'(idx);
    endfunction

    assign tick     = (cnt_q == LAST_CNT);
    assign last_idx = (index_q == LAST_IDX);

`ifdef PLAYBACK_PAUSE_EN
    assign count_en = (state_q != StIdle) && (state_q != StPause);
`else
    assign count_en = (state_q != StIdle);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            index_q      <= '0;
            track_q      <= '0;
            rom_req      <= 1'b0;
            rom_addr     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef PLAYBACK_PAUSE_EN
            pause_pend_q <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            if (ena) begin
                // Free-running while busy; ticks that land outside WAIT are simply dropped.
                if (count_en) begin
                    cnt_q <= tick ? '0 : cnt_q + 1'b1;
                end
                if (cmd_stop && (state_q != StIdle)) begin
                    state_q <= StIdle;
                    rom_req <= 1'b0;
                    busy    <= 1'b0;
`ifdef PLAYBACK_PAUSE_EN
                    pause_pend_q <= 1'b0;
`endif
                end else begin
                    case (state_q)
                        StIdle: begin
                            if (cmd_play && !cmd_stop) begin
                                track_q  <= track_sel;
                                index_q  <= '0;
                                cnt_q    <= '0;
                                rom_addr <= track_addr(track_sel, '0);
                                rom_req  <= 1'b1;
                                busy     <= 1'b1;
                                state_q  <= StReq;
                            end
                        end
                        StWait: begin
`ifdef PLAYBACK_PAUSE_EN
                            if (cmd_pause) begin
                                state_q <= StPause;
                            end else
`endif
                            if (tick) begin
                                rom_addr <= track_addr(track_q, index_q);
                                rom_req  <= 1'b1;
                                state_q  <= StReq;
                            end
                        end
                        StReq: begin
                            if (rom_ack) begin
                                sample_out   <= rom_data;
                                sample_valid <= 1'b1;
                                rom_req      <= 1'b0;
`ifdef PLAYBACK_PAUSE_EN
                                pause_pend_q <= 1'b0;
`endif
                                if (last_idx) begin
                                    state_q <= StEnd;
                                end else begin
                                    index_q <= index_q + 1'b1;
`ifdef PLAYBACK_PAUSE_EN
                                    state_q <= (pause_pend_q || cmd_pause) ? StPause : StWait;
`else
                                    state_q <= StWait;
`endif
                                end
                            end
`ifdef PLAYBACK_PAUSE_EN
                            else if (cmd_pause) begin
                                pause_pend_q <= 1'b1;
                            end
`endif
                        end
                        StEnd: begin
                            if (loop_en) begin
                                index_q <= '0;
                                state_q <= StWait;
                            end else begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
`ifdef PLAYBACK_PAUSE_EN
                        StPause: begin
                            if (cmd_pause) begin
                                state_q <= StWait;
                            end
                        end
`endif
                        default: begin
                            state_q <= StIdle;
                            rom_req <= 1'b0;
                            busy    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with ADDR_W=8, TRACK_LEN=4, CLK_DIV=4 and a
// one-cycle-latency ROM model returning 0x1000+addr.
module tb_playback_sequencer;

    localparam int unsigned AW = 8;
    localparam int unsigned TL = 4;
    localparam int unsigned CD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          cmd_play = 1'b0;
    logic          cmd_stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [1:0]    track_sel = 2'd0;
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic          rom_ack;
    logic [15:0]   rom_data;
    logic [15:0]   sample_out;
    logic          sample_valid;
    logic          busy;
    logic          done;
`ifdef PLAYBACK_PAUSE_EN
    logic          cmd_pause = 1'b0;
`endif

    playback_sequencer #(
        .ADDR_W    (AW),
        .TRACK_LEN (TL),
        .CLK_DIV   (CD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cmd_play     (cmd_play),
        .cmd_stop     (cmd_stop),
`ifdef PLAYBACK_PAUSE_EN
        .cmd_pause    (cmd_pause),
`endif
        .loop_en      (loop_en),
        .track_sel    (track_sel),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // ROM model: ack one cycle after a request is seen, data valid alongside ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rom_ack <= 1'b0;
        else        rom_ack <= rom_req && !rom_ack;
    end
    assign rom_data = 16'h1000 + {8'h00, rom_addr};

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] addr_q[$];
    int            valid_q[$];
    int            done_cnt;
    int            done_at;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse cmd_play and record request addresses, sample_valid cycles and done pulses.
    task automatic play_and_run(input logic [1:0] trk, input int cycles);
        logic prev_req;
        addr_q.delete();
        valid_q.delete();
        done_cnt  = 0;
        done_at   = -1;
        prev_req  = rom_req;
        cmd_play  = 1'b1;
        track_sel = trk;
        for (int i = 1; i <= cycles; i++) begin
            step();
            if (i == 1) cmd_play = 1'b0;
            if (rom_req && !prev_req) addr_q.push_back(rom_addr);
            if (sample_valid) valid_q.push_back(i);
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            prev_req = rom_req;
        end
    endtask

    function automatic logic [31:0] addr_at(input int k);
        return (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hdead;
    endfunction

    function automatic int valid_at(input int k);
        return (k < valid_q.size()) ? valid_q[k] : -1;
    endfunction

    initial begin
        logic seen;

        // Power-on reset
        step();
        step();
        check("rst_req",   32'(rom_req),      32'd0);
        check("rst_addr",  32'(rom_addr),     32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_out",   32'(sample_out),   32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_done",  32'(done),         32'd0);
        rst_n = 1'b1;
        step();

        // One-shot playback of track 2
        loop_en = 1'b0;
        play_and_run(2'd2, 20);
        check("os_naddr", 32'(addr_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("os_addr%0d", k), addr_at(k), 32'h80 + k);
        check("os_nvalid", 32'(valid_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("os_vcyc%0d", k), 32'(valid_at(k)), 3 + 4 * k);
        check("os_ndone",  32'(done_cnt),   32'd1);
        check("os_donecyc", 32'(done_at),   32'd16);
        check("os_busy",   32'(busy),       32'd0);
        check("os_out",    32'(sample_out), 32'h1083);

        // Looping playback of track 2, then stop coinciding with an ack
        loop_en = 1'b1;
        play_and_run(2'd2, 30);
        check("lp_naddr", 32'(addr_q.size()), 32'd8);
        for (int k = 0; k < 8; k++) check($sformatf("lp_addr%0d", k), addr_at(k), 32'h80 + (k % 4));
        check("lp_nvalid", 32'(valid_q.size()), 32'd7);
        for (int k = 0; k < 7; k++) check($sformatf("lp_vcyc%0d", k), 32'(valid_at(k)), 3 + 4 * k);
        check("lp_ndone", 32'(done_cnt), 32'd0);
        check("lp_pre_req", 32'(rom_req),    32'd1);
        check("lp_pre_ack", 32'(rom_ack),    32'd1);
        check("lp_pre_out", 32'(sample_out), 32'h1082);
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        check("stop_valid", 32'(sample_valid), 32'd0);
        check("stop_out",   32'(sample_out),   32'h1082);
        check("stop_busy",  32'(busy),         32'd0);
        check("stop_req",   32'(rom_req),      32'd0);
        check("stop_done",  32'(done),         32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= done | rom_req | sample_valid;
        end
        check("stop_quiet", 32'(seen), 32'd0);
        loop_en = 1'b0;

        // ena low for 10 cycles during WAIT
        play_and_run(2'd0, 3);
        check("ena_first", addr_at(0), 32'h00);
        check("ena_out",   32'(sample_out), 32'h1000);
        ena  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen |= rom_req | sample_valid;
        end
        check("ena_hold",  32'(seen), 32'd0);
        check("ena_busy",  32'(busy), 32'd1);
        ena = 1'b1;
        step();
        check("ena_req1", 32'(rom_req), 32'd0);
        step();
        check("ena_req2", 32'(rom_req),  32'd1);
        check("ena_addr", 32'(rom_addr), 32'h01);
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        check("ena_stop", 32'(busy), 32'd0);

        // play and stop together from IDLE: stop wins
        cmd_play  = 1'b1;
        cmd_stop  = 1'b1;
        track_sel = 2'd1;
        step();
        cmd_play = 1'b0;
        cmd_stop = 1'b0;
        seen = busy | rom_req;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= busy | rom_req;
        end
        check("ps_idle", 32'(seen), 32'd0);

        // cmd_play while busy must not change the track
        play_and_run(2'd3, 3);
        check("pb_out", 32'(sample_out), 32'h10C0);
        cmd_play  = 1'b1;
        track_sel = 2'd1;
        step();
        cmd_play = 1'b0;
        step();
        check("pb_req",  32'(rom_req),  32'd1);
        check("pb_addr", 32'(rom_addr), 32'hC1);

        // Asynchronous reset in the middle of a request
        step();
        check("ar_pre_req", 32'(rom_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_req",   32'(rom_req),      32'd0);
        check("ar_busy",  32'(busy),         32'd0);
        check("ar_out",   32'(sample_out),   32'd0);
        check("ar_valid", 32'(sample_valid), 32'd0);
        check("ar_addr",  32'(rom_addr),     32'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= busy | rom_req | done;
        end
        check("ar_idle", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
